// File: rtl/ram_bus_pkg.sv
// rtl/ram_bus_pkg.sv - shared constants, region type and address decoder for the RAM bus responder
package ram_bus_pkg;

    localparam logic [15:0] DATA_ADDR_DEF = 16'hBF00;
    localparam logic [15:0] STAT_ADDR_DEF = 16'hBF01;

    localparam int STAT_TXNF = 0;
    localparam int STAT_RXNE = 1;
    localparam int STAT_OVF  = 2;

    // Value returned for unmapped reads and an empty mailbox
    localparam logic [15:0] BUS_IDLE = 16'h0000;

    typedef enum logic [1:0] {
        RGN_MEM,
        RGN_DATA,
        RGN_STAT,
        RGN_NONE
    } region_e;

    function automatic region_e decode_region(
        input logic [15:0] addr,
        input int          mem_aw,
        input logic [15:0] data_addr,
        input logic [15:0] stat_addr
    );
        if ((addr >> mem_aw) == 16'd0) return RGN_MEM;
        if (addr == data_addr)         return RGN_DATA;
        if (addr == stat_addr)         return RGN_STAT;
        return RGN_NONE;
    endfunction

endpackage

// File: rtl/ram_bus_responder_if.sv
// rtl/ram_bus_responder_if.sv - RAM bus control/address and host byte streams
interface ram_bus_responder_if;
    logic        ramEN;
    logic        ramOE;
    logic        ramWE;
    logic [15:0] ramAddr;
    logic [7:0]  hostTxData;
    logic        hostTxValid;
    logic        hostTxReady;
    logic [7:0]  hostRxData;
    logic        hostRxValid;
    logic        hostRxReady;

    modport slave (
        input  ramEN, ramOE, ramWE, ramAddr, hostTxReady, hostRxData, hostRxValid,
        output hostTxData, hostTxValid, hostRxReady
    );

    modport master (
        output ramEN, ramOE, ramWE, ramAddr, hostTxReady, hostRxData, hostRxValid,
        input  hostTxData, hostTxValid, hostRxReady
    );
endinterface

// File: rtl/ram_bus_responder_sync_fifo.sv
// rtl/ram_bus_responder_sync_fifo.sv - single-clock FIFO with wrap-bit pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = i_pop & ~o_empty;
    // A push into a full FIFO is only accepted when the head leaves the same cycle
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/ram_bus_responder.sv
// rtl/ram_bus_responder.sv - RAM bus target: word memory plus byte mailbox to a host stream
module ram_bus_responder
    import ram_bus_pkg::*;
#(
    parameter int          MEM_AW     = 8,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DATA_ADDR  = DATA_ADDR_DEF,
    parameter logic [15:0] STAT_ADDR  = STAT_ADDR_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    ram_bus_responder_if.slave   bus,
    inout  wire  [15:0]          ramData
);
    logic        r_en_q;
    logic        r_oe_q;
    logic        r_we_q;
    logic [15:0] r_addr_q;
    logic [15:0] r_data_q;
    logic        r_rd_active;
    logic [15:0] r_rd_data;
    logic        r_tx_ovf;
    logic [15:0] r_mem [2**MEM_AW];

    region_e     w_wr_rgn;
    region_e     w_rd_rgn;
    logic        w_commit;
    logic        w_rd_cond;
    logic        w_rd_start;
    logic        w_drive_en;
    logic        w_tx_push;
    logic        w_tx_pop;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic [7:0]  w_tx_head;
    logic        w_rx_push;
    logic        w_rx_pop;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic [7:0]  w_rx_head;
    logic [15:0] w_stat;
    logic [15:0] w_rd_next;

    assign w_wr_rgn   = decode_region(r_addr_q, MEM_AW, DATA_ADDR, STAT_ADDR);
    assign w_rd_rgn   = decode_region(bus.ramAddr, MEM_AW, DATA_ADDR, STAT_ADDR);

    // WE released (possibly together with EN) after a cycle of selected write
    assign w_commit   = ~RST & ~r_we_q & bus.ramWE & ~r_en_q;
    assign w_rd_cond  = ~bus.ramEN & ~bus.ramOE & bus.ramWE;
    assign w_rd_start = w_rd_cond & (r_oe_q | ~r_rd_active | (bus.ramAddr != r_addr_q));
    assign w_drive_en = r_rd_active & w_rd_cond;
    assign ramData    = w_drive_en ? r_rd_data : 16'hzzzz;

    assign w_tx_push  = w_commit & (w_wr_rgn == RGN_DATA);
    assign w_tx_pop   = ~w_tx_empty & bus.hostTxReady;
    assign w_rx_push  = bus.hostRxValid & bus.hostRxReady;
    assign w_rx_pop   = w_rd_start & (w_rd_rgn == RGN_DATA) & ~w_rx_empty;

    assign bus.hostTxValid = ~w_tx_empty;
    assign bus.hostTxData  = w_tx_head;
    assign bus.hostRxReady = ~RST & ~w_rx_full;

    always_comb begin
        w_stat            = '0;
        w_stat[STAT_TXNF] = ~w_tx_full;
        w_stat[STAT_RXNE] = ~w_rx_empty;
        w_stat[STAT_OVF]  = r_tx_ovf;
    end

    always_comb begin
        w_rd_next = BUS_IDLE;
        unique case (w_rd_rgn)
            RGN_MEM:  w_rd_next = r_mem[bus.ramAddr[MEM_AW-1:0]];
            RGN_DATA: if (!w_rx_empty) w_rd_next = {8'h00, w_rx_head};
            RGN_STAT: w_rd_next = w_stat;
            RGN_NONE: w_rd_next = BUS_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_en_q      <= 1'b1;
            r_oe_q      <= 1'b1;
            r_we_q      <= 1'b1;
            r_addr_q    <= '0;
            r_data_q    <= '0;
            r_rd_active <= 1'b0;
            r_rd_data   <= '0;
            r_tx_ovf    <= 1'b0;
        end else begin
            r_en_q      <= bus.ramEN;
            r_oe_q      <= bus.ramOE;
            r_we_q      <= bus.ramWE;
            r_addr_q    <= bus.ramAddr;
            r_data_q    <= ramData;
            r_rd_active <= w_rd_cond;
            // Mailbox reads have side effects, so their value is frozen for the whole access
            if (w_rd_start || w_rd_rgn == RGN_MEM || w_rd_rgn == RGN_NONE)
                r_rd_data <= w_rd_next;
            if (w_tx_push && w_tx_full && !w_tx_pop)
                r_tx_ovf <= 1'b1;
            else if (w_rd_start && w_rd_rgn == RGN_STAT)
                r_tx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_commit && w_wr_rgn == RGN_MEM)
            r_mem[r_addr_q[MEM_AW-1:0]] <= r_data_q;
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_tx_push),
        .i_data  (r_data_q[7:0]),
        .i_pop   (w_tx_pop),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (w_tx_head)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_rx_push),
        .i_data  (bus.hostRxData),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head)
    );
endmodule
